score_keeper: RTL

- Producer side of the score/ball interface that the on-screen text renderer consumes.
- Counts paddle hits as a two-digit BCD score (dig1:dig0) and tracks balls remaining (ball).
- Runs a small game state machine: IDLE, PLAY, OVER.
- Commits events only on the frame tick, so the digits stay stable for the whole of each displayed frame.

---
 rtl/score_keeper.sv | 112 +++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// score_keeper: game scoring producer for the on-screen text renderer.
// Keeps a two-digit BCD score and the balls remaining, and runs the
// IDLE/PLAY/OVER game state machine. Hits and misses are gathered in pending
// registers and only committed on frame_tick, so the displayed digits never
// change in the middle of a frame.
//
// Input pulses: start, hit, miss and frame_tick are one-cycle, active-high
// strobes sampled on the rising clock edge. There is no backpressure: a pulse
// is either acted on or ignored (for example, in the wrong state) in its cycle.
module score_keeper #(
  parameter int BALLS  = 3,
  parameter int PEND_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  input  logic       frame_tick,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [1:0] ball,
  output logic       game_over,
  output logic       playing
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int              SUM_W      = 8 + PEND_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [1:0]      BALLS_INIT = 2'(BALLS);

  state_t            state;
  logic [PEND_W-1:0] pend_hits;
  logic              pend_miss;

  // Score arithmetic in binary, then split back into BCD digits. Working in
  // binary keeps the saturation at 99 a single compare, whatever PEND_W is.
  logic [6:0]       score_bin;
  logic [SUM_W-1:0] score_sum;
  logic [6:0]       score_sat;
  logic [3:0]       new_dig0;
  logic [3:0]       new_dig1;

  assign score_bin = 7'({3'b000, dig1} * 7'd10) + {3'b000, dig0};
  assign score_sum = SUM_W'(score_bin) + SUM_W'(pend_hits);
  assign score_sat = (score_sum >= SUM_W'(99)) ? 7'd99 : score_sum[6:0];
  assign new_dig1  = 4'(score_sat / 7'd10);
  assign new_dig0  = 4'(score_sat % 7'd10);

  // Game state machine; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dig0      <= 4'd0;
      dig1      <= 4'd0;
      ball      <= BALLS_INIT;
      game_over <= 1'b0;
      playing   <= 1'b0;
      pend_hits <= '0;
      pend_miss <= 1'b0;
    end else begin
      case (state)
        IDLE, OVER: begin
          // hit, miss and frame_tick are ignored here; only start matters.
          if (start) begin
            state     <= PLAY;
            dig0      <= 4'd0;
            dig1      <= 4'd0;
            ball      <= BALLS_INIT;
            game_over <= 1'b0;
            playing   <= 1'b1;
            pend_hits <= '0;
            pend_miss <= 1'b0;
          end
        end
        PLAY: begin
          if (frame_tick) begin
            dig0 <= new_dig0;
            dig1 <= new_dig1;
            // Events arriving with the tick seed the next frame's pending set.
            pend_hits <= PEND_W'(hit);
            pend_miss <= miss;
            if (pend_miss) begin
              ball <= ball - 2'd1;
              if (ball == 2'd1) begin
                state     <= OVER;
                game_over <= 1'b1;
                playing   <= 1'b0;
              end
            end
          end else begin
            if (hit && (pend_hits != PEND_MAX))
              pend_hits <= pend_hits + PEND_W'(1);
            if (miss)
              pend_miss <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          game_over <= 1'b0;
          playing   <= 1'b0;
        end
      endcase
    end
  end

endmodule
